// File: rtl/tournament_predictor_if.sv
// Fetch-side lookup and resolve-side update signals of the tournament predictor.
// The master is the pipeline driving requests; the slave is the predictor.
interface tournament_predictor_if #(
  parameter int INDEX_WIDTH = 10
);
  logic                   busy;
  logic                   pred_req;
  logic [31:0]            pred_pc;
  logic                   pred_valid;
  logic                   pred_taken;
  logic [INDEX_WIDTH-1:0] pred_gidx;
  logic                   upd_valid;
  logic [31:0]            upd_pc;
  logic [INDEX_WIDTH-1:0] upd_gidx;
  logic                   upd_taken;

  modport master (
    output pred_req, pred_pc, upd_valid, upd_pc, upd_gidx, upd_taken,
    input  busy, pred_valid, pred_taken, pred_gidx
  );

  modport slave (
    input  pred_req, pred_pc, upd_valid, upd_pc, upd_gidx, upd_taken,
    output busy, pred_valid, pred_taken, pred_gidx
  );
endinterface

// File: rtl/tournament_predictor.sv
// Tournament branch predictor: bimodal + gshare + chooser counter tables, a
// one-cycle lookup path, a two-stage forwarding update pipe and a reset-time init sweep.
module tournament_predictor #(
  parameter int INDEX_WIDTH = 10,
  parameter int HIST_WIDTH  = 10,
  parameter int CTR_WIDTH   = 2
) (
  input logic                  clk,
  input logic                  rstn,
  tournament_predictor_if.slave bus
);
  localparam int ENTRIES = 1 << INDEX_WIDTH;

  typedef logic [CTR_WIDTH-1:0]   ctr_t;
  typedef logic [INDEX_WIDTH-1:0] idx_t;
  typedef enum logic {INIT, READY} state_t;

  localparam ctr_t CTR_MAX  = '1;
  localparam ctr_t CTR_WEAK = ctr_t'((1 << (CTR_WIDTH - 1)) - 1);

  function automatic ctr_t sat_step(input ctr_t c, input logic up);
    if (up) return (c == CTR_MAX) ? c : c + ctr_t'(1);
    return (c == '0) ? c : c - ctr_t'(1);
  endfunction

  function automatic ctr_t chooser_step(input ctr_t cho, input ctr_t bim,
                                        input ctr_t gsh, input logic taken);
    if (bim[CTR_WIDTH-1] == gsh[CTR_WIDTH-1]) return cho;
    return sat_step(cho, gsh[CTR_WIDTH-1] == taken);
  endfunction

  ctr_t bim_mem [ENTRIES];
  ctr_t gsh_mem [ENTRIES];
  ctr_t cho_mem [ENTRIES];

  state_t                state, state_nxt;
  idx_t                  init_cnt, init_cnt_nxt;
  logic [HIST_WIDTH-1:0] ghr, ghr_nxt;
  logic                  ready;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= INIT;
      init_cnt <= '0;
    end else begin
      state    <= state_nxt;
      init_cnt <= init_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    init_cnt_nxt = init_cnt;
    if (state == INIT) begin
      init_cnt_nxt = init_cnt + idx_t'(1);
      if (init_cnt == '1) state_nxt = READY;
    end
  end

  assign ready    = (state == READY);
  assign bus.busy = ~ready;

  // p0: lookup index formation; tables read and prediction registered at the edge
  idx_t pred_bidx, pred_gidx_p0;
  assign pred_bidx    = bus.pred_pc[INDEX_WIDTH+1:2];
  assign pred_gidx_p0 = pred_bidx ^ idx_t'(ghr);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      bus.pred_valid <= 1'b0;
      bus.pred_taken <= 1'b0;
      bus.pred_gidx  <= '0;
    end else begin
      bus.pred_valid <= ready & bus.pred_req;
      if (ready && bus.pred_req) begin
        bus.pred_taken <= cho_mem[pred_bidx][CTR_WIDTH-1] ? gsh_mem[pred_gidx_p0][CTR_WIDTH-1]
                                                          : bim_mem[pred_bidx][CTR_WIDTH-1];
        bus.pred_gidx  <= pred_gidx_p0;
      end
    end
  end

  if (HIST_WIDTH == 1) begin : g_hist1
    assign ghr_nxt = bus.upd_taken;
  end else begin : g_histn
    assign ghr_nxt = {ghr[HIST_WIDTH-2:0], bus.upd_taken};
  end

  // p0: update read stage, with the p1 write forwarded onto matching indexes
  logic upd_vld_p0;
  idx_t upd_bidx_p0, upd_gidx_p0;
  ctr_t bim_rd_p0, gsh_rd_p0, cho_rd_p0;

  logic vld_p1, taken_p1;
  idx_t bidx_p1, gidx_p1;
  ctr_t bim_p1, gsh_p1, cho_p1;
  ctr_t bim_new, gsh_new, cho_new;

  assign upd_vld_p0  = ready & bus.upd_valid;
  assign upd_bidx_p0 = bus.upd_pc[INDEX_WIDTH+1:2];
  assign upd_gidx_p0 = bus.upd_gidx;

  assign bim_rd_p0 = (vld_p1 && bidx_p1 == upd_bidx_p0) ? bim_new : bim_mem[upd_bidx_p0];
  assign cho_rd_p0 = (vld_p1 && bidx_p1 == upd_bidx_p0) ? cho_new : cho_mem[upd_bidx_p0];
  assign gsh_rd_p0 = (vld_p1 && gidx_p1 == upd_gidx_p0) ? gsh_new : gsh_mem[upd_gidx_p0];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      vld_p1 <= 1'b0;
      ghr    <= '0;
    end else begin
      vld_p1 <= upd_vld_p0;
      if (upd_vld_p0) ghr <= ghr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    bidx_p1  <= upd_bidx_p0;
    gidx_p1  <= upd_gidx_p0;
    bim_p1   <= bim_rd_p0;
    gsh_p1   <= gsh_rd_p0;
    cho_p1   <= cho_rd_p0;
    taken_p1 <= bus.upd_taken;
  end

  // p1: counter arithmetic and the shared table write port
  assign bim_new = sat_step(bim_p1, taken_p1);
  assign gsh_new = sat_step(gsh_p1, taken_p1);
  assign cho_new = chooser_step(cho_p1, bim_p1, gsh_p1, taken_p1);

  logic wr_en;
  idx_t wr_bidx, wr_gidx;
  ctr_t wr_bim, wr_gsh, wr_cho;

  always_comb begin
    wr_en   = vld_p1;
    wr_bidx = bidx_p1;
    wr_gidx = gidx_p1;
    wr_bim  = bim_new;
    wr_gsh  = gsh_new;
    wr_cho  = cho_new;
    if (state == INIT) begin
      wr_en   = 1'b1;
      wr_bidx = init_cnt;
      wr_gidx = init_cnt;
      wr_bim  = CTR_WEAK;
      wr_gsh  = CTR_WEAK;
      wr_cho  = CTR_WEAK;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      bim_mem[wr_bidx] <= wr_bim;
      cho_mem[wr_bidx] <= wr_cho;
      gsh_mem[wr_gidx] <= wr_gsh;
    end
  end

  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.pred_pc[31:INDEX_WIDTH+2], bus.pred_pc[1:0],
                            bus.upd_pc[31:INDEX_WIDTH+2], bus.upd_pc[1:0]};
endmodule

// File: doc/tournament_predictor.md
Name: tournament_predictor

Overview:
- Parametrised successor to the bimodal/gshare PHT predictors: bimodal table + gshare table + chooser table, each 2^INDEX_WIDTH saturating counters of CTR_WIDTH bits.
- Sits in the fetch stage (predict port) and the branch-resolve stage (update port).
- Adds over the earlier predictors:
  - configurable history and counter width;
  - back-to-back updates with read-modify-write forwarding;
  - hardware table initialisation after reset.

Parameters:
INDEX_WIDTH, 10, log2 entries per table (3..14).
HIST_WIDTH, 10, global history bits (1..INDEX_WIDTH); zero-extended to INDEX_WIDTH before XOR.
CTR_WIDTH, 2, saturating counter width (2..4).

Ports:
clk  in  1  clock.
rstn  in  1  reset; synchronous, active-low.
busy  out  1  1 while the init sweep runs.
pred_req  in  1  lookup request for pred_pc.
pred_pc  in  32  fetch PC.
pred_valid  out  1  pred_req delayed one cycle (forced 0 while busy).
pred_taken  out  1  final prediction, valid when pred_valid.
pred_gidx  out  INDEX_WIDTH  gshare index used for this lookup; carried down the pipe to the update.
upd_valid  in  1  resolved conditional branch.
upd_pc  in  32  PC of the resolved branch.
upd_gidx  in  INDEX_WIDTH  pred_gidx captured at predict time.
upd_taken  in  1  actual outcome.

Behaviour:
- Reset (rstn=0 at a clock edge):
  - ghr=0; pipeline valids cleared.
  - busy=1, pred_valid=0, pred_taken=0, pred_gidx=0.
  - FSM enters INIT with init counter 0.
- INIT state:
  - Each cycle, writes entry init_cnt of all three tables via the write port.
  - Values written: bimodal=gshare=2^(CTR_WIDTH-1)-1 (weakly not-taken); chooser=2^(CTR_WIDTH-1)-1 (weakly bimodal).
  - After entry 2^INDEX_WIDTH-1 → READY. busy falls in the cycle after the last write, so busy is high for exactly 2^INDEX_WIDTH cycles after reset release.
  - upd_valid is dropped: no table write, no ghr shift. pred_req is ignored.
  - rstn low mid-INIT restarts the sweep from entry 0.
- Lookup (READY), pred_req in cycle N:
  - bidx = pred_pc[INDEX_WIDTH+1:2]; gidx = bidx ^ zext(ghr).
  - Synchronous table read; outputs registered at edge N+1 (latency 1).
  - pred_taken = MSB(chooser) ? MSB(gshare) : MSB(bimodal). pred_gidx = gidx of cycle N.
  - Without pred_req, pred_valid=0 and pred_taken/pred_gidx hold their previous values.
  - No forwarding on the lookup path: a lookup colliding with a same-cycle write returns the pre-write value.
- Update pipeline, 2 stages, accepts upd_valid every cycle:
  - S1 (cycle U): read all three tables at bidx_u = upd_pc[INDEX_WIDTH+1:2] and upd_gidx. ghr <= {ghr[HIST_WIDTH-2:0], upd_taken} at edge U. For HIST_WIDTH=1, ghr <= upd_taken.
  - S2 (cycle U+1): compute new counters and write them.
    - bimodal and gshare: +1 if taken, saturating at 2^CTR_WIDTH-1; -1 if not taken, saturating at 0.
    - chooser changes only when MSB(bimodal) != MSB(gshare): +1 (saturating) if the gshare MSB equals the outcome, else -1 (saturating).
- Forwarding: if S2 writes index X in the same cycle S1 reads index X (per table), S1 uses the S2 new value instead of the RAM output. Consecutive updates to one entry therefore accumulate exactly: two taken updates from 0 give 2.
- Width rule: all counter arithmetic is CTR_WIDTH bits; no wrap past 0 or max.

Test Plan:
1. INDEX_WIDTH=4, CTR_WIDTH=2: release rstn → busy=1 for 16 cycles, then 0. pred_req at pc=0x40 → next cycle pred_valid=1, pred_taken=0; table entries read back 1.
2. Three consecutive upd_valid cycles, pc=0x40, gidx=0x0, taken=1 → bimodal[0]=3 (1→2→3, saturating) and gshare[0]=3. Chooser unchanged, since MSBs are equal on every update. Then pred_req pc=0x40 with ghr=0b0111: gshare index is 0x7 (entry still 1), bimodal gives 1 → pred_taken=1.
3. HIST_WIDTH=4: ten taken updates then pred_req pc=0x0 → pred_gidx=0xF (ghr=0xF). Ghr wraps correctly with older bits shifted out.
4. Bimodal[2]=2, gshare[5]=1, chooser[2]=1; update pc=0x8, gidx=5, taken=0 → chooser[2]=2, bimodal[2]=1, gshare[5]=0.
5. Saturation at 0: five not-taken updates to one entry from init → counter 0, never wraps to 3.
6. Reset asserted at INIT cycle 7 → busy stays 1 and a full 16-cycle sweep follows. upd_valid pulses during INIT leave ghr=0 and all entries at 1.
